// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the memory-stage load/store unit: FSM states and the
// rv32i load/store funct3 width codes.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  localparam logic [3:0]  MBE_ALL    = 4'b1111;
  localparam logic [31:0] WDATA_ZERO = 32'h0000_0000;

  // funct3[1:0] is the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-cache port between the load/store unit (master) and the cache (slave).
interface mem_stage_lsu_if;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [3:0]  data_mbe;
  logic [31:0] data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;

  modport master (
    output data_read, data_write, data_addr, data_mbe, data_wdata,
    input  data_resp, data_rdata
  );

  modport slave (
    input  data_read, data_write, data_addr, data_mbe, data_wdata,
    output data_resp, data_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_store_align.sv
// Store lane steering: byte mask and replicated write data from the width
// code and address offset, plus the misalignment flag shared with loads.
module mem_stage_lsu_store_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  output logic [3:0]  mbe_o,
  output logic [31:0] wdata_o,
  output logic        mis_o
);

  always_comb begin
    mbe_o   = 4'b0000;
    wdata_o = WDATA_ZERO;
    case (store_funct3_t'(funct3_i))
      SB: begin
        mbe_o   = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      SH: begin
        mbe_o   = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      SW: begin
        mbe_o   = MBE_ALL;
        wdata_o = store_data_i;
      end
      default: begin
        mbe_o   = 4'b0000;
        wdata_o = WDATA_ZERO;
      end
    endcase
  end

  assign mis_o = is_misaligned(funct3_i, addr_lo_i);

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues one held cache request per load/store, stalls the
// pipeline until the cache responds, and latches the load word and offset.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  mem_stage_lsu_if.master       dbus,
  output logic                  stall,
  output logic [31:0]           load_word,
  output logic [1:0]            load_offset,
  output logic                  misalign
);

  lsu_state_t  state_q;
  logic        read_q, write_q, misalign_q;
  logic [31:0] addr_q, wdata_q, load_word_q;
  logic [3:0]  mbe_q;
  logic [1:0]  off_q, load_offset_q;

  logic        op_s, mis_s;
  logic [3:0]  st_mbe_s, mbe_d;
  logic [31:0] st_wdata_s, wdata_d;

  mem_stage_lsu_store_align u_store_align (
    .funct3_i     (funct3),
    .addr_lo_i    (addr[1:0]),
    .store_data_i (store_data),
    .mbe_o        (st_mbe_s),
    .wdata_o      (st_wdata_s),
    .mis_o        (mis_s)
  );

  assign op_s    = mem_valid & (mem_read | mem_write);
  assign mbe_d   = mem_write ? st_mbe_s : MBE_ALL;
  assign wdata_d = mem_write ? st_wdata_s : WDATA_ZERO;
  assign stall   = op_s & ~mis_s & (state_q != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      misalign_q    <= 1'b0;
      addr_q        <= 32'h0000_0000;
      mbe_q         <= 4'b0000;
      wdata_q       <= 32'h0000_0000;
      off_q         <= 2'b00;
      load_word_q   <= 32'h0000_0000;
      load_offset_q <= 2'b00;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_s && !mis_s) begin
            read_q  <= ~mem_write;
            write_q <= mem_write;
            addr_q  <= {addr[31:2], 2'b00};
            mbe_q   <= mbe_d;
            wdata_q <= wdata_d;
            off_q   <= addr[1:0];
            state_q <= ACCESS;
          end else if (op_s && mis_s) begin
            misalign_q <= 1'b1;
          end
        end
        ACCESS: begin
          // request fields stay frozen here regardless of pipeline inputs
          if (dbus.data_resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (read_q) begin
              load_word_q   <= dbus.data_rdata;
              load_offset_q <= off_q;
            end
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbus.data_read  = read_q;
  assign dbus.data_write = write_q;
  assign dbus.data_addr  = addr_q;
  assign dbus.data_mbe   = mbe_q;
  assign dbus.data_wdata = wdata_q;
  assign load_word       = load_word_q;
  assign load_offset     = load_offset_q;
  assign misalign        = misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a pipeline driver and a cache model push
// expectations from a byte-level reference model; a monitor pops and compares.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, misalign;
  logic [31:0] load_word;
  logic [1:0]  load_offset;

  mem_stage_lsu_if bus ();

  mem_stage_lsu dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .dbus        (bus.master),
    .stall       (stall),
    .load_word   (load_word),
    .load_offset (load_offset),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mis;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic [1:0]  off;
    bit          b2b;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
  } cresp_t;

  exp_t   exp_q[$];
  cresp_t cache_q[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  bit     last_access = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: access of 2**size bytes; store lanes repeat the low bytes.
  function automatic exp_t model(input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd);
    exp_t e;
    int size = 1 << f3[1:0];
    int off  = int'(a[1:0]);
    int base = off - (off % size);
    e.mis  = (off % size) != 0;
    e.wr   = wr;
    e.addr = a & 32'hFFFF_FFFC;
    e.off  = a[1:0];
    e.b2b  = 1'b0;
    e.mbe  = 4'b0000;
    e.wdata = 32'h0;
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= base && i < base + size) e.mbe[i] = 1'b1;
        e.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
      end
    end else begin
      e.mbe = 4'b1111;
    end
    return e;
  endfunction

  // Cache model: answers each request after its scheduled latency.
  initial begin
    cresp_t cr;
    bus.data_resp  = 1'b0;
    bus.data_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if ((bus.data_read || bus.data_write) && cache_q.size() > 0) begin
        cr = cache_q.pop_front();
        repeat (cr.lat - 1) begin @(posedge clk); #1; end
        bus.data_resp  = 1'b1;
        bus.data_rdata = cr.rdata;
        @(posedge clk); #1;
        bus.data_resp  = 1'b0;
        bus.data_rdata = $urandom;
      end
    end
  end

  // Monitor: compares request rises, held fields, misalign pulses, load capture.
  initial begin
    exp_t        cur, e;
    bit          prev_req = 1'b0;
    bit          req, pend = 1'b0;
    int          last_resp_c = -100;
    logic [31:0] model_lw = 32'h0;
    logic [1:0]  model_lo = 2'b00;
    cur = '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0};
    forever begin
      @(negedge clk);
      req = bus.data_read | bus.data_write;
      if (pend) begin
        chk("load_word", load_word, model_lw);
        chk("load_offset", {30'h0, load_offset}, {30'h0, model_lo});
        pend = 1'b0;
      end
      if (req && !prev_req) begin
        chk("req_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("req_not_misaligned", cur.mis, 0);
          chk("req_write", bus.data_write, cur.wr);
          chk("req_read", bus.data_read, !cur.wr);
          chk("req_addr", bus.data_addr, cur.addr);
          chk("req_mbe", bus.data_mbe, cur.mbe);
          chk("req_wdata", bus.data_wdata, cur.wdata);
          if (cur.b2b) chk("b2b_gap", cyc - (last_resp_c + 1), 2);
        end
      end else if (req) begin
        chk("hold_write", bus.data_write, cur.wr);
        chk("hold_addr", bus.data_addr, cur.addr);
        chk("hold_mbe", bus.data_mbe, cur.mbe);
        chk("hold_wdata", bus.data_wdata, cur.wdata);
      end
      if (misalign) begin
        chk("misalign_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("misalign_kind", e.mis, 1);
        end
      end
      if (req && bus.data_resp) begin
        last_resp_c = cyc;
        if (!cur.wr) begin
          model_lw = bus.data_rdata;
          model_lo = cur.off;
        end
        pend = 1'b1;
      end
      prev_req = req;
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input int lat, input logic [31:0] rdat);
    exp_t e;
    int   cnt = 0;
    int   exp_stall;
    e = model(wr, f3, a, sd);
    e.b2b = last_access && !e.mis;
    exp_q.push_back(e);
    if (!e.mis) cache_q.push_back('{lat, rdat});
    exp_stall = e.mis ? 0 : lat + 1;
    mem_valid = 1'b1; mem_read = rd; mem_write = wr;
    funct3 = f3; addr = a; store_data = sd;
    forever begin
      @(negedge clk);
      if (!stall || cnt > 200) break;
      cnt++;
      if (cnt >= 2) store_data = $urandom;
    end
    chk("stall_cycles", cnt, exp_stall);
    @(posedge clk); #1;
    last_access = !e.mis;
  endtask

  task automatic idle(input int n);
    mem_valid = $urandom_range(0, 1);
    mem_read = 1'b0; mem_write = 1'b0;
    addr = $urandom; funct3 = 3'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_stall", stall, 0);
      @(posedge clk); #1;
    end
    last_access = 1'b0;
  endtask

  initial begin
    logic [2:0] lf[5];
    int         kind, gap, lat;
    logic [2:0] f3;
    logic [31:0] a;
    exp_t       e;
    lf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
    repeat (2) @(posedge clk); #1;
    chk("rst_read", bus.data_read, 0);
    chk("rst_write", bus.data_write, 0);
    chk("rst_addr", bus.data_addr, 0);
    chk("rst_mbe", bus.data_mbe, 0);
    chk("rst_wdata", bus.data_wdata, 0);
    chk("rst_load_word", load_word, 0);
    chk("rst_load_offset", load_offset, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset while a long load is outstanding; its late response must be ignored
    e = model(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    exp_q.push_back(e);
    cache_q.push_back('{8, 32'hCAFE_F00D});
    mem_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_4000;
    repeat (3) @(negedge clk);
    chk("pre_rst_read", bus.data_read, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_read", bus.data_read, 0);
    chk("midrst_addr", bus.data_addr, 0);
    chk("midrst_mbe", bus.data_mbe, 0);
    mem_valid = 1'b0; mem_read = 1'b0;
    #1 chk("midrst_stall", stall, 0);
    @(negedge clk); @(negedge clk); #2 rst = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("late_resp_load_word", load_word, 0);
    chk("late_resp_no_read", bus.data_read, 0);
    last_access = 1'b0;

    issue(1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 1, 32'h0);
    idle(1);
    issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 2, 32'h0);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 5, 32'h8001_1234);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 1, 32'h0);
    idle(2);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 1, 32'h1357_9BDF);
    issue(1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'h2468_ACE0, 1, 32'h0);

    for (int n = 0; n < 150; n++) begin
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
      kind = $urandom_range(0, 2);
      f3 = (kind == 0) ? lf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~((2'd1 << f3[1:0]) - 2'd1);
      lat = $urandom_range(1, 4);
      issue(kind != 1, kind != 0, f3, a, $urandom, lat, $urandom);
    end

    idle(4);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the pipelined RV32I core. It sits between the EX/MEM pipeline register and the data-cache port. It turns a load or store in MEM into a single held request with word-aligned address, byte mask and replicated store data, and stalls the pipeline until the cache responds. It latches the returned word and byte offset for the writeback-side load extraction (lb/lbu/lh/lhu/lw regfilemux selects).

## Interface
Parameters:
- none (RV32 fixed: 32-bit address/data, 4-bit byte mask)

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_valid  in  1  EX/MEM holds a valid instruction
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store; wins if both read and write set
- funct3  in  3  load/store width code (rv32i funct3 encoding)
- addr  in  32  effective address (EX/MEM alu_out)
- store_data  in  32  rs2 value for stores
- data_read  out  1  cache read request, registered
- data_write  out  1  cache write request, registered
- data_addr  out  32  {addr[31:2],2'b00}, registered
- data_mbe  out  4  byte mask, registered
- data_wdata  out  32  aligned store data, registered
- data_resp  in  1  cache completion pulse
- data_rdata  in  32  cache read word, valid with data_resp
- stall  out  1  hold IF..MEM pipeline registers (combinational)
- load_word  out  32  latched read word
- load_offset  out  2  latched addr[1:0] of last load
- misalign  out  1  one-cycle pulse: access suppressed, misaligned

## Operation
- States: IDLE, ACCESS, DONE.
- op = mem_valid & (mem_read | mem_write). mis = (half and addr[0]) or (word and addr[1:0]!=0).
- IDLE: op & !mis → register request outputs, go ACCESS. op & mis → misalign pulse next cycle, no request, stay IDLE. data_resp ignored.
- ACCESS: request outputs held stable. On data_resp: drop data_read/data_write next edge; loads capture data_rdata→load_word and addr[1:0]→load_offset. Go DONE.
- DONE: one cycle, stall low so the pipeline advances; go IDLE.
- stall = op & !mis & (state != DONE).
- Store mask/data: sb mbe=4'b0001<<addr[1:0], wdata={4{store_data[7:0]}}; sh mbe=4'b0011<<{addr[1],1'b0}, wdata={2{store_data[15:0]}}; sw mbe=4'b1111, wdata=store_data.
- Loads: mbe=4'b1111, wdata=0. Sign/zero extension happens downstream.
- load_word/load_offset hold until the next completed load; stores leave them unchanged.

## Timing
- Reset (async): state IDLE; data_read, data_write, misalign=0; data_addr, data_mbe, data_wdata, load_word=0; load_offset=0. stall follows its combinational equation.
- Op visible in cycle 0 → request high in cycle 1 → resp in cycle k≥1 → request low and DONE in k+1 → next op evaluated in k+2. Minimum stall: 2 cycles for a 1-cycle cache.
- Only one request outstanding. Request fields do not change while in ACCESS, even if inputs change.
- Reset mid-ACCESS: request dropped immediately. A late data_resp after reset is ignored in IDLE.
- A misaligned op costs no stall. Pipeline control must flush or trap on the misalign pulse.

## Structure
- Shared package lsu: lsu_state_t enum {IDLE, ACCESS, DONE}.
- Width codes reuse the existing rv32i load/store funct3 typedefs.
- Sub-module store_align: combinational funct3/addr[1:0]/store_data → mbe, wdata, mis. Instantiated once.

## Test plan
- sw addr 0x1000 data 0xDEADBEEF, resp after 1 cycle → data_write=1, mbe=1111, wdata=0xDEADBEEF, data_addr=0x1000; stall high 2 cycles.
- sb addr 0x1003 data 0x000000A5 → mbe=1000, wdata=0xA5A5A5A5, data_addr=0x1000.
- lh addr 0x2002, resp after 5 cycles with rdata 0x8001_1234 → load_word=0x80011234, load_offset=2; request held 5 cycles, stall 6 cycles.
- lw addr 0x3001 → misalign pulse 1 cycle, no data_read, stall never high.
- rst asserted mid-ACCESS, then data_resp arrives → all outputs 0 immediately, resp ignored, load_word unchanged from 0.
- Back-to-back lw then sw, 1-cycle cache → second request rises exactly 2 cycles after the first response.
